// File: rtl/acc_bank_pkg.sv
// Shared types for the BeeF accumulator unit: source selector, control and byte aliases.
package acc_bank_pkg;

  localparam int unsigned ACC_SRC_W = 2;

  // Accumulator load source selector.
  typedef enum logic [ACC_SRC_W-1:0] {
    ACC_SRC_ALU   = 2'd0,
    ACC_SRC_MEM   = 2'd1,
    ACC_SRC_IMM   = 2'd2,
    ACC_SRC_DELTA = 2'd3
  } acc_src_e;

  // Single-bit datapath control.
  typedef logic CONTROL;

  // WIDTH=8 data alias.
  typedef logic [7:0] BYTE;

endpackage

// File: rtl/acc_save_stack.sv
// LIFO save stack for the accumulator.
// Ports: clock/reset_n; push/pop request (both = swap); wr_data is the value saved;
// top_c is the current top entry; restore_c flags that the accumulator should take top_c;
// depth/err are registered; full_c/empty_c decode depth.
module acc_save_stack
  import acc_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             top_c,
  output logic                         restore_c,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full_c,
  output logic                         empty_c,
  output logic                         err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [DW-1:0]    r_depth;
  logic             r_err;

  CONTROL           w_push_ok;
  CONTROL           w_pop_ok;
  CONTROL           w_swap_ok;
  CONTROL           w_fault;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;

  // Operation decode; faulting requests leave the stack untouched.
  always_comb begin
    full_c    = (r_depth == DW'(DEPTH));
    empty_c   = (r_depth == '0);
    w_push_ok = push & ~pop & ~full_c;
    w_pop_ok  = pop & ~push & ~empty_c;
    w_swap_ok = push & pop & ~empty_c;
    w_fault   = (push & ~pop & full_c) | (pop & empty_c);
    w_top_idx = AW'(r_depth - DW'(1));
    w_wr_idx  = w_swap_ok ? w_top_idx : AW'(r_depth);
  end

  assign top_c     = r_mem[w_top_idx];
  assign restore_c = w_pop_ok | w_swap_ok;
  assign depth     = r_depth;
  assign err       = r_err;

  // Pointer and sticky error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push_ok)     r_depth <= r_depth + DW'(1);
      else if (w_pop_ok) r_depth <= r_depth - DW'(1);
      if (w_fault)       r_err   <= 1'b1;
    end
  end

  // Storage; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (w_push_ok | w_swap_ok) r_mem[w_wr_idx] <= wr_data;
  end

endmodule

// File: rtl/acc_bank.sv
// Accumulator unit: source mux, +/-1 step (wrap or saturate), accumulator register and save stack.
// Ports: clock/reset_n; acc_write/acc_src/delta_dec select the load; alu_out/mem_out/imm data;
// push/pop drive the save stack; acc_out/depth/stack_err registered, acc_zero/stack_full/stack_empty decodes.
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         acc_write,
  input  logic [1:0]                   acc_src,
  input  logic                         delta_dec,
  input  logic [WIDTH-1:0]             alu_out,
  input  logic [WIDTH-1:0]             mem_out,
  input  logic [WIDTH-1:0]             imm,
  input  logic                         push,
  input  logic                         pop,
  output logic [WIDTH-1:0]             acc_out,
  output logic                         acc_zero,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         stack_err
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_delta;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_acc_nxt;
  CONTROL           w_restore;

  acc_save_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .wr_data   (r_acc),
    .top_c     (w_top),
    .restore_c (w_restore),
    .depth     (depth),
    .full_c    (stack_full),
    .empty_c   (stack_empty),
    .err       (stack_err)
  );

  // Step by one; in saturating builds the ends of the range are sticky.
  always_comb begin
    w_delta = delta_dec ? (r_acc - WIDTH'(1)) : (r_acc + WIDTH'(1));
    if (SATURATE) begin
      if (delta_dec && (r_acc == '0))       w_delta = '0;
      else if (!delta_dec && (r_acc == '1)) w_delta = '1;
    end
  end

  // Source select and load priority: write beats restore beats hold.
  always_comb begin
    w_src = alu_out;
    case (acc_src_e'(acc_src))
      ACC_SRC_ALU:   w_src = alu_out;
      ACC_SRC_MEM:   w_src = mem_out;
      ACC_SRC_IMM:   w_src = imm;
      ACC_SRC_DELTA: w_src = w_delta;
      default:       w_src = alu_out;
    endcase
    w_acc_nxt = r_acc;
    if (acc_write)      w_acc_nxt = w_src;
    else if (w_restore) w_acc_nxt = w_top;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_acc <= '0;
    else          r_acc <= w_acc_nxt;
  end

  assign acc_out  = r_acc;
  assign acc_zero = (r_acc == '0);

endmodule
